// File: rtl/d_sram_like_bridge_pkg.sv
// Shared encodings for the datapath-to-sram-like bridges: FSM state codes and
// the sram-like transfer size codes.
package d_sram_like_bridge_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/wen_to_size.sv
// Byte write-enable to sram-like transfer size decoder. Reads (all-zero) and
// any unrecognised pattern decode as a full word.
module wen_to_size
    import d_sram_like_bridge_pkg::*;
#(
    parameter int BE_W = 4
) (
    input  logic [BE_W-1:0] wen,
    output logic [1:0]      size
);

    localparam logic [BE_W-1:0] HALF_LO = {{(BE_W/2){1'b0}}, {(BE_W/2){1'b1}}};
    localparam logic [BE_W-1:0] HALF_HI = {{(BE_W/2){1'b1}}, {(BE_W/2){1'b0}}};

    always_comb begin
        size = SIZE_W;
        if ($onehot(wen))
            size = SIZE_B;
        else if (wen == HALF_LO || wen == HALF_HI)
            size = SIZE_H;
    end

endmodule

// File: rtl/d_sram_like_bridge.sv
// Memory-stage data port to sram-like split-transaction bridge. Stalls the
// pipeline while an access is in flight and holds load data until release.
module d_sram_like_bridge
    import d_sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_sram_en,
    input  logic [DATA_W/8-1:0] data_sram_wen,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic [DATA_W-1:0]   data_sram_rdata,
    input  logic                longest_stall,
    output logic                d_stall,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
);

    logic [1:0]        state;
    logic [DATA_W-1:0] rd_buf;
    logic              wr_q;
    logic              idle_issue;

    // Gated by rst so the outputs are quiet while reset is held even if the
    // datapath still presents an enabled access.
    assign idle_issue = (state == ST_IDLE) && data_sram_en && !rst;

    assign data_req = idle_issue || (state == ST_REQ);
    assign d_stall  = idle_issue || (state == ST_REQ) || (state == ST_RESP);

    assign data_wr    = |data_sram_wen;
    assign data_addr  = data_sram_addr;
    assign data_wdata = data_sram_wdata;

    assign data_sram_rdata = rd_buf;

    wen_to_size #(.BE_W(DATA_W/8)) u_size (
        .wen  (data_sram_wen),
        .size (data_size)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            rd_buf <= '0;
            wr_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_sram_en) begin
                        wr_q  <= |data_sram_wen;
                        state <= data_addr_ok ? ST_RESP : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (data_addr_ok)
                        state <= ST_RESP;
                end
                ST_RESP: begin
                    if (data_data_ok) begin
                        if (!wr_q)
                            rd_buf <= data_rdata;
                        state <= ST_HOLD;
                    end
                end
                default: begin
                    // HOLD: the instruction retires on the first unstalled edge.
                    if (!longest_stall)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Directed bench for d_sram_like_bridge: a bus responder driven step by step,
// with expected load data queued at issue and compared when the access retires.
module tb_d_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        longest_stall;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    d_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .longest_stall   (longest_stall),
        .d_stall         (d_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered just after a posedge with the FSM in IDLE. Returns just after the
    // edge on which the access retires (HOLD -> IDLE).
    task automatic do_access(input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rsp,
                             input int aw, input int dw, input int hold,
                             input logic [1:0] exp_size, input bit stray);
        int          req_n;
        int          stall_n;
        logic [31:0] exp_rd;
        req_n   = 0;
        stall_n = 0;
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        if (wen == 4'b0000) sb.push_back(rsp);
        for (int i = 0; i <= aw; i++) begin
            data_addr_ok = (i == aw);
            data_data_ok = stray && (i < aw);
            data_rdata   = 32'h5A5A_0000 + i;
            @(negedge clk);
            check("req_phase_req", data_req, 1'b1);
            check("req_phase_wr", data_wr, |wen);
            check("req_phase_size", data_size, exp_size);
            check("req_phase_addr", data_addr, addr);
            check("req_phase_wdata", data_wdata, wdata);
            check("req_phase_rdata_kept", data_sram_rdata, last_rd);
            req_n   += int'(data_req);
            stall_n += int'(d_stall);
            @(posedge clk); #1;
        end
        data_addr_ok = 1'b0;
        for (int i = 1; i <= dw; i++) begin
            data_data_ok = (i == dw);
            data_rdata   = (i == dw) ? rsp : 32'hA5A5_0000 + i;
            @(negedge clk);
            check("resp_phase_req", data_req, 1'b0);
            check("resp_phase_stall", d_stall, 1'b1);
            req_n   += int'(data_req);
            stall_n += int'(d_stall);
            @(posedge clk); #1;
        end
        data_data_ok = 1'b0;
        data_rdata   = 32'h0BAD_0BAD;
        if (wen == 4'b0000) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_empty observed=0 expected=1");
                exp_rd = last_rd;
            end else begin
                exp_rd = sb.pop_front();
            end
        end else begin
            exp_rd = last_rd;
        end
        last_rd = exp_rd;
        for (int h = 0; h <= hold; h++) begin
            longest_stall = (h < hold);
            @(negedge clk);
            check("hold_stall", d_stall, 1'b0);
            check("hold_req", data_req, 1'b0);
            check("hold_rdata", data_sram_rdata, exp_rd);
            stall_n += int'(d_stall);
            @(posedge clk); #1;
        end
        longest_stall = 1'b0;
        check("req_cycles", req_n, aw + 1);
        check("stall_cycles", stall_n, aw + 1 + dw);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        data_sram_en = 1'b0; data_sram_wen = 4'b0; data_sram_addr = '0; data_sram_wdata = '0;
        longest_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        last_rd = '0;
        #2;
        check("reset_req", data_req, 1'b0);
        check("reset_stall", d_stall, 1'b0);
        check("reset_rdata", data_sram_rdata, 32'h0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Word read, minimum latency.
        do_access(4'b0000, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 2'd2, 1'b0);
        data_sram_en = 1'b0;
        @(negedge clk);
        check("t1_idle_req", data_req, 1'b0);
        check("t1_rdata_after", data_sram_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Byte store, 3 addr wait cycles, data_ok 2 cycles after accept.
        do_access(4'b0100, 32'h1000_0003, 32'h00AB_0000, 32'hCAFE_F00D, 3, 2, 0, 2'd0, 1'b0);
        data_sram_en = 1'b0;
        @(posedge clk); #1;

        // Read retires under an external stall held 5 cycles.
        do_access(4'b0000, 32'h1000_0020, 32'h0, 32'h1234_5678, 0, 1, 5, 2'd2, 1'b0);

        // Back-to-back load then halfword store: no bubble between them.
        do_access(4'b0000, 32'h1000_0024, 32'h0, 32'h8765_4321, 1, 1, 0, 2'd2, 1'b0);
        do_access(4'b1100, 32'h1000_0026, 32'hBEEF_0000, 32'hFFFF_FFFF, 0, 1, 0, 2'd1, 1'b0);
        data_sram_en = 1'b0;

        // Stray data_ok while IDLE, then while REQ.
        data_data_ok = 1'b1; data_rdata = 32'hFEED_FACE;
        @(negedge clk);
        check("stray_idle_req", data_req, 1'b0);
        check("stray_idle_stall", d_stall, 1'b0);
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        check("stray_idle_rdata", data_sram_rdata, 32'h8765_4321);
        check("stray_idle_state", d_stall, 1'b0);
        @(posedge clk); #1;
        do_access(4'b0000, 32'h1000_0030, 32'h0, 32'h0F0F_F0F0, 2, 1, 0, 2'd2, 1'b1);
        data_sram_en = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset while in RESP.
        data_sram_en = 1'b1; data_sram_wen = 4'b0; data_sram_addr = 32'h1000_0040;
        data_addr_ok = 1'b1;
        @(negedge clk);
        check("rst_issue_req", data_req, 1'b1);
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        #2;
        check("rst_resp_stall", d_stall, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_req", data_req, 1'b0);
        check("rst_async_stall", d_stall, 1'b0);
        check("rst_async_rdata", data_sram_rdata, 32'h0);
        data_sram_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        @(posedge clk); #1;
        do_access(4'b0000, 32'h1000_0044, 32'h0, 32'h2468_ACE0, 0, 1, 0, 2'd2, 1'b0);
        data_sram_en = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
